// File: rtl/eth_tx_arb_if.sv
// Shared byte/handshake bundle between the two frame sources, the arbiter and eth_tx.
// The arbiter connects through the slave modport; sources and the eth_tx side use master.
interface eth_tx_arb_if #(parameter int CNT_W = 16);
  logic             Req0, Gnt0, Byte_Valid0, Pkt_Done0;
  logic [7:0]       Byte0;
  logic             Req1, Gnt1, Byte_Valid1, Pkt_Done1;
  logic [7:0]       Byte1;
  logic [7:0]       Eth_Byte;
  logic             Eth_Byte_Valid, Eth_Pkt_Rdy, Tx_En;
  logic             Busy, Timeout_Err;
  logic [CNT_W-1:0] Frame_Cnt0, Frame_Cnt1;

  modport slave (
    input  Req0, Byte0, Byte_Valid0, Pkt_Done0,
    input  Req1, Byte1, Byte_Valid1, Pkt_Done1,
    input  Tx_En,
    output Gnt0, Gnt1, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy,
    output Busy, Timeout_Err, Frame_Cnt0, Frame_Cnt1
  );

  modport master (
    output Req0, Byte0, Byte_Valid0, Pkt_Done0,
    output Req1, Byte1, Byte_Valid1, Pkt_Done1,
    output Tx_En,
    input  Gnt0, Gnt1, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy,
    input  Busy, Timeout_Err, Frame_Cnt0, Frame_Cnt1
  );
endinterface

// File: rtl/eth_tx_arb.sv
// Two-source round-robin arbiter in front of eth_tx: grant, forward bytes, commit, wait for
// Tx_En, then hold off for the inter-frame gap. Define ETH_TX_ARB_STATS_EN for frame counters.
module eth_tx_arb #(
  parameter int IFG_CYCLES     = 48,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input logic        Clk,
  input logic        Rst,
  eth_tx_arb_if.slave bus
);
  localparam int TMAX = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, GRANT, WAIT_TX, SEND, IFG} state_t;

  state_t        state;
  logic          ptr, owner;
  logic [1:0]    gnt;
  logic [10:0]   byte_cnt;
  logic [TW-1:0] tmr;
  logic [7:0]    eth_byte;
  logic          eth_valid, pkt_rdy, tmo_err;

  logic [1:0]      req, bv, done;
  logic [1:0][7:0] byt;
  logic            win, sel_bv, sel_done, commit;
  logic [7:0]      sel_byte;

  assign req  = {bus.Req1, bus.Req0};
  assign bv   = {bus.Byte_Valid1, bus.Byte_Valid0};
  assign done = {bus.Pkt_Done1, bus.Pkt_Done0};
  assign byt  = {bus.Byte1, bus.Byte0};

  assign win      = (req[0] & req[1]) ? ptr : req[1];
  assign sel_bv   = bv[owner];
  assign sel_done = done[owner];
  assign sel_byte = byt[owner];
  // A byte accepted in the Pkt_Done cycle already makes the frame non-empty.
  assign commit   = (state == GRANT) && sel_done && ((byte_cnt != '0) || sel_bv);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      gnt       <= '0;
      byte_cnt  <= '0;
      tmr       <= '0;
      eth_byte  <= '0;
      eth_valid <= 1'b0;
      pkt_rdy   <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      eth_valid <= 1'b0;
      pkt_rdy   <= 1'b0;
      tmo_err   <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          owner    <= win;
          gnt      <= win ? 2'b10 : 2'b01;
          byte_cnt <= '0;
          state    <= GRANT;
        end
        GRANT: begin
          if (sel_bv) begin
            eth_byte  <= sel_byte;
            eth_valid <= 1'b1;
            if (byte_cnt != 11'h7ff) byte_cnt <= byte_cnt + 11'd1;
          end
          if (sel_done) begin
            gnt <= '0;
            ptr <= ~owner;
            if (commit) begin
              pkt_rdy <= 1'b1;
              tmr     <= '0;
              state   <= WAIT_TX;
            end else begin
              state <= IDLE;
            end
          end
        end
        WAIT_TX: begin
          if (bus.Tx_En) state <= SEND;
          else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else tmr <= tmr + TW'(1);
        end
        SEND: if (!bus.Tx_En) begin
          tmr   <= TW'(IFG_CYCLES - 1);
          state <= IFG;
        end
        IFG: begin
          if (tmr == '0) state <= IDLE;
          else tmr <= tmr - TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Gnt0           = gnt[0];
  assign bus.Gnt1           = gnt[1];
  assign bus.Eth_Byte       = eth_byte;
  assign bus.Eth_Byte_Valid = eth_valid;
  assign bus.Eth_Pkt_Rdy    = pkt_rdy;
  assign bus.Busy           = (state != IDLE);
  assign bus.Timeout_Err    = tmo_err;

`ifdef ETH_TX_ARB_STATS_EN
  logic [1:0][CNT_W-1:0] frame_cnt;

  // Counted at commit, so a frame that later times out still counts.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) frame_cnt <= '0;
    else for (int i = 0; i < 2; i++)
      if (commit && (owner == 1'(i))) frame_cnt[i] <= frame_cnt[i] + CNT_W'(1);
  end

  assign bus.Frame_Cnt0 = frame_cnt[0];
  assign bus.Frame_Cnt1 = frame_cnt[1];
`else
  assign bus.Frame_Cnt0 = '0;
  assign bus.Frame_Cnt1 = '0;
`endif
endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomized bench for eth_tx_arb: drives both sources and an eth_tx Tx_En model, and checks
// grant order, byte forwarding, commit, IFG, timeout and reset against a transaction-level model.
module tb_eth_tx_arb;
  localparam int IFG = 48, TMO = 4096, CW = 16;

  logic clk = 1'b0, rst = 1'b1;
  always #10 clk = ~clk;

  eth_tx_arb_if #(.CNT_W(CW)) bus();
  eth_tx_arb #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .Clk(clk), .Rst(rst), .bus(bus)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, rdy_cnt = 0;
  int fall_cyc = -1, commit_cyc = -1;
  int tx_dly = 10, tx_len = 8;
  bit tx_hold_low = 1'b0;

  // Reference model state: round-robin preference, committed frames, held output byte.
  bit         m_ptr = 1'b0;
  int         m_cnt [2] = '{0, 0};
  logic [7:0] last_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.Eth_Pkt_Rdy === 1'b1) rdy_cnt <= rdy_cnt + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(); @(negedge clk); endtask

  // eth_tx stand-in: Tx_En rises tx_dly cycles after each commit and stays up tx_len cycles.
  initial begin
    bus.Tx_En = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Eth_Pkt_Rdy === 1'b1 && !tx_hold_low) begin
        repeat (tx_dly) @(negedge clk);
        bus.Tx_En = 1'b1;
        repeat (tx_len) @(negedge clk);
        bus.Tx_En = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  function automatic int winner(bit r0, bit r1, bit p);
    return (r0 && r1) ? int'(p) : (r1 ? 1 : 0);
  endfunction

  function automatic logic gnt_of(int i);
    return (i == 0) ? bus.Gnt0 : bus.Gnt1;
  endfunction

  task automatic set_src(int i, bit v, logic [7:0] b, bit pd);
    if (i == 0) begin bus.Byte_Valid0 = v; bus.Byte0 = b; bus.Pkt_Done0 = pd; end
    else        begin bus.Byte_Valid1 = v; bus.Byte1 = b; bus.Pkt_Done1 = pd; end
  endtask

  task automatic check_cnt(string tag);
`ifdef ETH_TX_ARB_STATS_EN
    check({tag, "_cnt0"}, 32'(bus.Frame_Cnt0), 32'(m_cnt[0] % (1 << CW)));
    check({tag, "_cnt1"}, 32'(bus.Frame_Cnt1), 32'(m_cnt[1] % (1 << CW)));
`else
    check({tag, "_cnt0"}, 32'(bus.Frame_Cnt0), 32'd0);
    check({tag, "_cnt1"}, 32'(bus.Frame_Cnt1), 32'd0);
`endif
  endtask

  task automatic wait_gnt(output int who, output int at);
    who = -1; at = -1;
    for (int k = 0; k < 6000; k++) begin
      if (bus.Gnt0 === 1'b1 || bus.Gnt1 === 1'b1) begin
        who = (bus.Gnt1 === 1'b1) ? 1 : 0; at = cyc; return;
      end
      tick();
    end
    check("gnt_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 6000; k++) begin
      if (bus.Busy === 1'b0) return;
      tick();
    end
    check("idle_wait_expired", 32'd0, 32'd1);
  endtask

  // Entered at a negedge where Gnt[who] is visible; returns two cycles after Pkt_Done.
  task automatic send_frame(int who, int n, logic [7:0] base);
    int sent = 0;
    bit fin = 1'b0;
    check("gnt_other_low", 32'(gnt_of(1 - who)), 32'd0);
    while (!fin) begin
      bit v, pd;
      logic [7:0] b;
      v  = (sent < n) && ($urandom_range(0, 3) != 0);
      pd = ((sent + int'(v)) == n) && ($urandom_range(0, 2) == 0);
      b  = base + 8'(sent);
      set_src(who, v, b, pd);
      set_src(1 - who, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              $urandom_range(0, 7) == 0);
      if (v) sent++;
      tick();
      check("byte_valid", 32'(bus.Eth_Byte_Valid), 32'(v));
      if (v) last_byte = b;
      check("byte_data", 32'(bus.Eth_Byte), 32'(last_byte));
      if (pd) fin = 1'b1;
      else check("gnt_held", 32'(gnt_of(who)), 32'd1);
    end
    m_ptr = (who == 0);
    if (n > 0) begin m_cnt[who]++; commit_cyc = cyc; end
    check("gnt_drop", 32'(gnt_of(who)), 32'd0);
    check("pkt_rdy", 32'(bus.Eth_Pkt_Rdy), 32'(n > 0));
    check("busy_after_done", 32'(bus.Busy), 32'(n > 0));
    check_cnt("commit");
    if (who == 0) bus.Req0 = 1'b0; else bus.Req1 = 1'b0;
    set_src(0, 1'b0, 8'h00, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0);
    tick();
    check("pkt_rdy_single", 32'(bus.Eth_Pkt_Rdy), 32'd0);
    check("valid_after_frame", 32'(bus.Eth_Byte_Valid), 32'd0);
  endtask

  initial begin
    int who, at, r0;
    bit seen;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    set_src(0, 1'b0, 8'h00, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0);

    // Reset state with both sources already requesting.
    repeat (3) tick();
    check("rst_gnt0", 32'(bus.Gnt0), 32'd0);
    check("rst_gnt1", 32'(bus.Gnt1), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_valid", 32'(bus.Eth_Byte_Valid), 32'd0);
    check("rst_byte", 32'(bus.Eth_Byte), 32'd0);
    check("rst_tmo", 32'(bus.Timeout_Err), 32'd0);
    check_cnt("rst");
    rst = 1'b0;
    tick();
    check("rr_first_gnt0", 32'(bus.Gnt0), 32'd1);
    tx_dly = 10; tx_len = 12;
    send_frame(0, 4, 8'h10);
    wait_gnt(who, at);
    check("rr_second_who", 32'(who), 32'd1);
    // Gnt rises IFG+1 edges after the first edge sampling Tx_En low: IFG+2 in negedge counts.
    check("ifg_regrant", 32'(at - fall_cyc), 32'(IFG + 2));
    send_frame(1, 4, 8'h20);

    // Lone requester, 40-byte frame, single-cycle grant latency from idle.
    wait_idle();
    bus.Req0 = 1'b1;
    tick();
    check("lone_gnt0", 32'(bus.Gnt0), 32'd1);
    send_frame(0, 40, 8'h01);

    // Empty frame on requester 1 must move the pointer back to requester 0.
    wait_idle();
    bus.Req1 = 1'b1;
    tick();
    check("empty_gnt1", 32'(bus.Gnt1), 32'd1);
    send_frame(1, 0, 8'h00);
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    tick();
    check("ptr_after_empty", 32'(bus.Gnt0), 32'(m_ptr == 1'b0));
    send_frame(0, 3, 8'h30);
    wait_gnt(who, at);
    check("pending_who", 32'(who), 32'd1);
    send_frame(1, 2, 8'h40);

    // Commit with Tx_En never rising.
    wait_idle();
    tx_hold_low = 1'b1;
    bus.Req0 = 1'b1;
    tick();
    check("tmo_gnt0", 32'(gnt_of(winner(1'b1, 1'b0, m_ptr))), 32'd1);
    send_frame(0, 5, 8'h50);
    bus.Req1 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < TMO + 50 && !seen; k++) begin
      if (bus.Timeout_Err === 1'b1) seen = 1'b1;
      else begin
        if (bus.Gnt1 === 1'b1) check("gnt_before_tmo", 32'd1, 32'd0);
        tick();
      end
    end
    check("tmo_seen", 32'(seen), 32'd1);
    check("tmo_latency", 32'(cyc - commit_cyc), 32'(TMO));
    check("tmo_busy", 32'(bus.Busy), 32'd0);
    tick();
    check("tmo_pulse", 32'(bus.Timeout_Err), 32'd0);
    check("tmo_regrant", 32'(bus.Gnt1), 32'd1);
    tx_hold_low = 1'b0; tx_dly = 3; tx_len = 6;
    send_frame(1, 2, 8'h60);

    // Asynchronous reset in the middle of a grant.
    wait_idle();
    bus.Req0 = 1'b1;
    tick();
    check("mid_gnt0", 32'(bus.Gnt0), 32'd1);
    set_src(0, 1'b1, 8'h77, 1'b0);
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    check("arst_gnt0", 32'(bus.Gnt0), 32'd0);
    check("arst_valid", 32'(bus.Eth_Byte_Valid), 32'd0);
    check("arst_byte", 32'(bus.Eth_Byte), 32'd0);
    check("arst_busy", 32'(bus.Busy), 32'd0);
    m_ptr = 1'b0; m_cnt = '{0, 0}; last_byte = 8'h00;
    check_cnt("arst");
    bus.Req0 = 1'b0;
    set_src(0, 1'b0, 8'h00, 1'b0);
    r0 = rdy_cnt;
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    check("no_rdy_after_rst", 32'(rdy_cnt), 32'(r0));
    check("idle_after_rst", 32'(bus.Busy), 32'd0);

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 30; it++) begin
      int n, exp_who;
      if (!bus.Req0 && !bus.Req1) begin
        int pat = $urandom_range(1, 3);
        bus.Req0 = pat[0]; bus.Req1 = pat[1];
      end
      exp_who = winner(bus.Req0, bus.Req1, m_ptr);
      tx_dly = $urandom_range(1, 30); tx_len = $urandom_range(1, 20);
      wait_gnt(who, at);
      check("rand_who", 32'(who), 32'(exp_who));
      if (who < 0) break;
      n = $urandom_range(0, 10);
      send_frame(who, n, 8'($urandom_range(0, 255)));
    end
    wait_idle();
    check_cnt("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
